// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter and sequencer for the single-port 32-word data memory.
// Port 0 is the core load/store path and port 1 is the test/loader master.
// One request is granted at a time. Each transaction runs IDLE (grant) ->
// ACCESS (memory cycle) -> registered response in the following cycle.
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined     : round-robin tie-break between the two ports
//   not defined : fixed priority, port 0 wins ties (no pointer register)
//
// Parameters:
//   AW  word-address width; valid addresses are 0 .. 2^AW-1
//   DW  data width
//
// Ports:
//   CLK                   clock, all state updates on posedge
//   RST                   asynchronous active-low reset
//   p0_req / p1_req       level request, held until the matching gnt
//   p0_we / p1_we         1 = store, 0 = load
//   p0_addr / p1_addr     32-bit word address
//   p0_wdata / p1_wdata   store data
//   p0_gnt / p1_gnt       one-cycle grant (combinational from req and state)
//   p0_rvalid / p1_rvalid one-cycle response strobe (loads and stores)
//   p0_rdata / p1_rdata   load data, nonzero only with rvalid
//   p0_err / p1_err       out-of-range flag, only with rvalid
//   mem_we/mem_addr/mem_wd memory command, driven only in ACCESS
//   mem_rd                combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_rvalid,
  output logic          p1_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p0_err,
  output logic          p1_err,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          id_q, id_d;          // 0 = port 0 owns the transaction
  logic          p0_rvalid_q, p0_rvalid_d;
  logic          p1_rvalid_q, p1_rvalid_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          p0_err_q, p0_err_d;
  logic          p1_err_q, p1_err_d;
  logic          win_s;               // 1 = port 1 wins this IDLE cycle
  logic          in_range_s;
  logic [DW-1:0] rdata_s;

`ifdef DMEM_ARB_RR_EN
  logic          last_q, last_d;      // port granted most recently
`endif

  // Upper address bits beyond the memory size must be zero.
  assign in_range_s = (addr_q[31:AW] == {(32-AW){1'b0}});

  // Tie-break: round-robin favours the port not granted last; fixed
  // priority always favours port 0.
  always_comb begin
    win_s = 1'b0;
`ifdef DMEM_ARB_RR_EN
    if (p0_req && p1_req) begin
      win_s = ~last_q;
    end else begin
      win_s = ~p0_req;
    end
`else
    win_s = ~p0_req;
`endif
  end

  // Next-state, grant and memory-command decode.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    id_d        = id_q;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = {DW{1'b0}};
    p1_rdata_d  = {DW{1'b0}};
    p0_err_d    = 1'b0;
    p1_err_d    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wd      = {DW{1'b0}};
    rdata_s     = {DW{1'b0}};
`ifdef DMEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        // Gating with RST keeps grants low while reset is asserted.
        if (RST && (p0_req || p1_req)) begin
          p0_gnt  = ~win_s;
          p1_gnt  = win_s;
          id_d    = win_s;
          we_d    = win_s ? p1_we    : p0_we;
          addr_d  = win_s ? p1_addr  : p0_addr;
          wdata_d = win_s ? p1_wdata : p0_wdata;
          state_d = ACCESS;
`ifdef DMEM_ARB_RR_EN
          last_d  = win_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        mem_addr = addr_q;
        mem_wd   = wdata_q;
        mem_we   = we_q & in_range_s;
        if (in_range_s && !we_q) begin
          rdata_s = mem_rd;
        end else begin
          rdata_s = {DW{1'b0}};
        end
        if (id_q) begin
          p1_rvalid_d = 1'b1;
          p1_rdata_d  = rdata_s;
          p1_err_d    = ~in_range_s;
        end else begin
          p0_rvalid_d = 1'b1;
          p0_rdata_d  = rdata_s;
          p0_err_d    = ~in_range_s;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched command and registered response.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= {DW{1'b0}};
      id_q        <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= {DW{1'b0}};
      p1_rdata_q  <= {DW{1'b0}};
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      id_q        <= id_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer; reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;

endmodule
